mw_addsub_seq: RTL and testbench

- Multi-word add/subtract sequencer.
- Takes operand word pairs LSW-first on a valid/ready stream and chains carry/borrow between words.
- Emits each result word on an output stream, then final carry, zero and overflow flags.
- Sits between the register-file/memory word fetch path and the ALU datapath, so arithmetic wider than WORD_SIZE runs one word per cycle.

---
 rtl/mw_addsub_seq.sv | 146 ++++++++++++++
 tb/tb_mw_addsub_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_addsub_seq.sv
// Multi-word add/subtract sequencer: LSW-first operand stream in, result words out, final flags.
// Optional carry-in port for ADC-style chaining is enabled by defining MW_ADDSUB_CIN_EN.
module mw_addsub_seq #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [CNT_W-1:0]     num_words,
`ifdef MW_ADDSUB_CIN_EN
  input  logic                 cin,
`endif
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] sum,
  output logic                 out_last,
  output logic                 done,
  output logic                 cout,
  output logic                 zero,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int MSB = WORD_SIZE - 1;

  state_t             state;
  state_t             state_nx;
  logic               sub_q;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               zacc;
  logic               ovf_p;
  logic [WORD_SIZE-1:0] y_eff;
  logic [WORD_SIZE:0]   wsum;
  logic               in_fire;
  logic               out_fire;
  logic               last_word;
  logic               fin;
  logic               start_ok;
  logic               c_first;

  assign y_eff     = sub_q ? ~y : y;
  assign wsum      = {1'b0, x} + {1'b0, y_eff}
                   + {{WORD_SIZE{1'b0}}, carry};
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_word = (cnt == CNT_W'(1));
  assign fin       = (state == DRAIN) && out_fire && out_last;
  assign start_ok  = (state == IDLE) && start;
  assign busy      = (state != IDLE);

`ifdef MW_ADDSUB_CIN_EN
  assign c_first = sub ? 1'b1 : cin;
`else
  assign c_first = sub;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and input handshake readiness
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_fire && last_word) state_nx = DRAIN;
      end
      DRAIN: begin
        if (fin) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operation context, carry chain and output word register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q     <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      zacc      <= 1'b1;
      ovf_p     <= 1'b0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (start_ok) begin
        sub_q <= sub;
        cnt   <= (num_words == '0) ? CNT_W'(1) : num_words;
        carry <= c_first;
        zacc  <= 1'b1;
      end
      if (in_fire) begin
        sum       <= wsum[MSB:0];
        out_valid <= 1'b1;
        out_last  <= last_word;
        carry     <= wsum[WORD_SIZE];
        zacc      <= zacc && (wsum[MSB:0] == '0);
        cnt       <= cnt - CNT_W'(1);
        ovf_p     <= (x[MSB] == y_eff[MSB])
                  && (wsum[MSB] != x[MSB]);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Completion pulse and sticky result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      cout <= 1'b0;
      zero <= 1'b1;
      ovf  <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        cout <= carry;
        zero <= zacc;
        ovf  <= ovf_p;
      end
    end
  end

endmodule

// File: tb/tb_mw_addsub_seq.sv
// Bench for mw_addsub_seq: directed cases plus randomized multi-word ops
// against a full-width arithmetic reference model.
module tb_mw_addsub_seq;

  localparam int W    = 16;
  localparam int MAXN = 255;
  localparam int MAXB = W * MAXN + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [7:0]   num_words;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         out_last;
  logic         done;
  logic         cout;
  logic         zero;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]    xw [256];
  logic [W-1:0]    yw [256];
  logic [MAXB-1:0] e_res;
  logic            e_cout;
  logic            e_zero;
  logic            e_ovf;

  mw_addsub_seq #(.WORD_SIZE(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .num_words(num_words), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum),
    .out_last(out_last), .done(done),
    .cout(cout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Whole-operand arithmetic on n*W-bit numbers
  task automatic model(input bit s, input int n);
    logic [MAXB-1:0] xa, ya, ye, t, m;
    logic xs, ys, rs;
    xa = '0;
    ya = '0;
    for (int i = 0; i < n; i++) begin
      xa[i*W +: W] = xw[i];
      ya[i*W +: W] = yw[i];
    end
    m = '1;
    m = m >> (MAXB - n * W);
    ye = s ? (~ya & m) : ya;
    t = xa + ye + MAXB'(s);
    e_cout = t[n*W];
    e_res  = t & m;
    e_zero = (e_res == '0);
    xs = xa[n*W-1];
    ys = ya[n*W-1];
    rs = e_res[n*W-1];
    e_ovf = s ? ((xs != ys) && (rs != xs))
              : ((xs == ys) && (rs != xs));
  endtask

  // mode 0: random valid/ready; 1: hold ready low 4 cycles on word 0; 2: full flow
  task automatic do_op(input bit s, input int nf, input int mode);
    int n, sent, got, cyc, stall_left;
    bit fin, fi, fo, hold;
    logic [W-1:0] hs;
    logic hl;
    n = (nf == 0) ? 1 : nf;
    model(s, n);
    sent = 0;
    got = 0;
    cyc = 0;
    stall_left = 4;
    fin = 0;
    hold = 0;
    hs = '0;
    hl = 0;
    @(negedge clk);
    start = 1;
    sub = s;
    num_words = nf[7:0];
    in_valid = 1;
    x = 16'($urandom);
    y = 16'($urandom);
    out_ready = 0;
    @(posedge clk);
    #1;
    check("busy_start", busy, 1);
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      start = 0;
      cyc++;
      in_valid = (sent < n) &&
                 (mode != 0 || $urandom_range(0, 3) != 0);
      x = (sent < n) ? xw[sent] : 16'($urandom);
      y = (sent < n) ? yw[sent] : 16'($urandom);
      if (mode == 1 && out_valid && got == 0 && stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = (mode != 0) || ($urandom_range(0, 2) != 0);
      end
      #1;
      if (hold) begin
        check("hold_sum", sum, hs);
        check("hold_last", out_last, hl);
        check("hold_valid", out_valid, 1);
      end
      hold = out_valid && !out_ready;
      hs = sum;
      hl = out_last;
      if (hold) check("stall_ready", in_ready, 0);
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      if (fo) begin
        check("sum", sum, e_res[got*W +: W]);
        check("last", out_last, got == n - 1);
        got++;
      end
      if (fi) sent++;
      @(posedge clk);
      #1;
      if (fi) begin
        check("lat_valid", out_valid, 1);
        check("lat_sum", sum, e_res[(sent-1)*W +: W]);
      end
      fin = fo && (got == n);
      check("done", done, fin);
    end
    if (!fin) check("timeout", 0, 1);
    check("words", got, n);
    check("cout", cout, e_cout);
    check("zero", zero, e_zero);
    check("ovf", ovf, e_ovf);
    check("busy_end", busy, 0);
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    @(posedge clk);
    #1;
    check("done_once", done, 0);
  endtask

  task automatic set_w(input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    xw[i] = a;
    yw[i] = b;
  endtask

  initial begin
    rst = 1;
    start = 0;
    sub = 0;
    num_words = 0;
    in_valid = 0;
    x = '0;
    y = '0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 1);
    check("rst_sum", sum, 0);
    @(negedge clk);
    rst = 0;

    set_w(0, 16'hFFFF, 16'h0001);
    set_w(1, 16'h0001, 16'h0000);
    do_op(0, 2, 2);
    check("t1_cout", cout, 0);
    check("t1_zero", zero, 0);
    check("t1_ovf", ovf, 0);

    set_w(0, 16'h0000, 16'h0001);
    set_w(1, 16'h0001, 16'h0000);
    do_op(1, 2, 0);
    check("t2_cout", cout, 1);
    check("t2_zero", zero, 0);

    set_w(0, 16'h0005, 16'h0005);
    do_op(1, 1, 2);
    check("t3a_cout", cout, 1);
    check("t3a_zero", zero, 1);
    set_w(0, 16'h0003, 16'h0005);
    do_op(1, 1, 0);
    check("t3b_cout", cout, 0);

    set_w(0, 16'h7FFF, 16'h0001);
    do_op(0, 1, 2);
    check("t4a_ovf", ovf, 1);
    check("t4a_cout", cout, 0);
    set_w(0, 16'h8000, 16'h8000);
    do_op(0, 1, 2);
    check("t4b_ovf", ovf, 1);
    check("t4b_cout", cout, 1);
    check("t4b_zero", zero, 1);

    for (int i = 0; i < 3; i++)
      set_w(i, 16'($urandom), 16'($urandom));
    do_op(0, 3, 1);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 8; i++) begin
        xw[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        yw[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      end
      do_op(1'($urandom_range(0, 1)), $urandom_range(0, 6),
            $urandom_range(0, 2));
    end

    for (int i = 0; i < MAXN; i++)
      set_w(i, 16'($urandom), 16'($urandom));
    do_op(1'($urandom_range(0, 1)), MAXN, 2);

    set_w(0, 16'h1234, 16'h0001);
    do_op(0, 1, 2);
    @(negedge clk);
    start = 1;
    sub = 0;
    num_words = 3;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    x = 16'h1111;
    y = 16'h2222;
    @(negedge clk);
    in_valid = 0;
    #1;
    check("mid_valid", out_valid, 1);
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_zero", zero, 1);
    @(negedge clk);
    rst = 0;
    set_w(0, 16'($urandom), 16'($urandom));
    set_w(1, 16'h5555, 16'h5555);
    do_op(0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
